vga_scanout: RTL and testbench

- Parametrised VGA scan-out engine: generates sync timing, framebuffer read addresses and pixel output from a synchronous single-port framebuffer read port.
- Next generation of the fixed 640x480 controller plus external row*640+col address multiply.
- Adds run-time modes (1x, 2x pixel-doubled, colour bars, blank), frame-synchronous mode switching and a clock-enable pixel rate instead of a divided clock.
- Sits between the VGA RAM port B and the board r/g/b/hs/vs pins.

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_timing_gen.sv | 62 ++++++
 rtl/vga_scanout.sv | 189 ++++++++++++++++++
 tb/tb_vga_scanout.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - mode encodings, default 640x480@60 timing and pipeline tag for the VGA scan-out engine
package vga_pkg;

  localparam logic [1:0] MODE_FB1X  = 2'd0;
  localparam logic [1:0] MODE_FB2X  = 2'd1;
  localparam logic [1:0] MODE_BARS  = 2'd2;
  localparam logic [1:0] MODE_BLANK = 2'd3;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Everything about one pixel that must travel alongside its framebuffer read.
  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic [9:0] h;
    logic [9:0] v;
    logic [2:0] bar;
    logic [1:0] mode;
  } pix_tag_t;

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - stage-0 h/v counters, raw sync/display windows and frame-start tick
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  output logic [9:0] h,
  output logic [9:0] v,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       de_raw,
  output logic       h_last,
  output logic       frame_wrap,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;
  logic       v_last;

  always_comb begin
    h_last     = (h_q == 10'(H_TOTAL - 1));
    v_last     = (v_q == 10'(V_TOTAL - 1));
    frame_wrap = h_last && v_last;
    h_d        = h_last ? 10'd0 : h_q + 10'd1;
    v_d        = v_q;
    if (h_last) begin
      v_d = v_last ? 10'd0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else if (pix_ce) begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h          = h_q;
  assign v          = v_q;
  assign hs_raw     = (h_q >= 10'(H_ACTIVE + H_FP)) && (h_q < 10'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_raw     = (v_q >= 10'(V_ACTIVE + V_FP)) && (v_q < 10'(V_ACTIVE + V_FP + V_SYNC));
  assign de_raw     = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));
  assign frame_tick = pix_ce && (h_q == 10'd0) && (v_q == 10'd0);

endmodule

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA scan-out: mode latch, multiplier-free fb addressing, 2-tick pixel pipeline
module vga_scanout
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = 0,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_ce,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [11:0]       fb_data,
  output logic [3:0]        r,
  output logic [3:0]        g,
  output logic [3:0]        b,
  output logic              hs,
  output logic              vs,
  output logic              de,
  output logic [9:0]        row_addr,
  output logic [9:0]        col_addr,
  output logic              frame_start
);

  localparam logic SYNC_INACT = (SYNC_POL == 0);
  localparam int   BAR_W      = H_ACTIVE / 8;

  logic [9:0] h, v;
  logic       hs_raw, vs_raw, de_raw, h_last, frame_wrap, frame_tick;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk        (clk),
    .rst        (rst),
    .pix_ce     (pix_ce),
    .h          (h),
    .v          (v),
    .hs_raw     (hs_raw),
    .vs_raw     (vs_raw),
    .de_raw     (de_raw),
    .h_last     (h_last),
    .frame_wrap (frame_wrap),
    .frame_tick (frame_tick)
  );

  logic [1:0]        active_mode_q, active_mode_d;
  logic              is_fb;
  logic [ADDR_W-1:0] col_off;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
  logic [9:0]        bar_px_q, bar_px_d;
  logic [2:0]        bar_k_q, bar_k_d;
  pix_tag_t          tag_q, tag_d;
  logic [3:0]        r_q, r_d, g_q, g_d, b_q, b_d;
  logic              hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [9:0]        row_q, row_d, col_q, col_d;
  logic              frame_start_q, frame_start_d;

  // Stage 0: the (0,0) tick already uses the newly latched mode so a frame never mixes modes.
  always_comb begin
    active_mode_d = frame_tick ? mode : active_mode_q;
    is_fb         = (active_mode_d == MODE_FB1X) || (active_mode_d == MODE_FB2X);
    col_off       = (active_mode_d == MODE_FB2X) ? ADDR_W'(h >> 1) : ADDR_W'(h);

    line_base_d = line_base_q;
    if (h_last) begin
      if (frame_wrap) begin
        line_base_d = '0;
      end else if (active_mode_d == MODE_FB1X) begin
        line_base_d = line_base_q + ADDR_W'(H_ACTIVE);
      end else if ((active_mode_d == MODE_FB2X) && v[0]) begin
        line_base_d = line_base_q + ADDR_W'(H_ACTIVE / 2);
      end
    end

    fb_addr_d = fb_addr_q;
    if (!is_fb) begin
      fb_addr_d = '0;
    end else if (de_raw) begin
      fb_addr_d = line_base_q + col_off;
    end

    bar_px_d = bar_px_q;
    bar_k_d  = bar_k_q;
    if (h_last) begin
      bar_px_d = '0;
      bar_k_d  = '0;
    end else if (h < 10'(H_ACTIVE)) begin
      if (bar_px_q == 10'(BAR_W - 1)) begin
        bar_px_d = '0;
        bar_k_d  = bar_k_q + 3'd1;
      end else begin
        bar_px_d = bar_px_q + 10'd1;
      end
    end

    tag_d.hs   = hs_raw;
    tag_d.vs   = vs_raw;
    tag_d.de   = de_raw;
    tag_d.h    = h;
    tag_d.v    = v;
    tag_d.bar  = bar_k_q;
    tag_d.mode = active_mode_d;
    frame_start_d = frame_tick;
  end

  // Stage 1: fb_data now holds the word addressed one tick earlier.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (tag_q.de) begin
      case (tag_q.mode)
        MODE_FB1X, MODE_FB2X: {b_d, g_d, r_d} = fb_data;
        MODE_BARS: begin
          r_d = {4{tag_q.bar[2]}};
          g_d = {4{tag_q.bar[1]}};
          b_d = {4{tag_q.bar[0]}};
        end
        default: ;
      endcase
    end
    hs_d  = tag_q.hs ^ SYNC_INACT;
    vs_d  = tag_q.vs ^ SYNC_INACT;
    de_d  = tag_q.de;
    row_d = tag_q.v;
    col_d = tag_q.h;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_mode_q <= MODE_FB1X;
      line_base_q   <= '0;
      fb_addr_q     <= '0;
      bar_px_q      <= '0;
      bar_k_q       <= '0;
      tag_q         <= '0;
      r_q           <= '0;
      g_q           <= '0;
      b_q           <= '0;
      hs_q          <= SYNC_INACT;
      vs_q          <= SYNC_INACT;
      de_q          <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= frame_start_d;
      if (pix_ce) begin
        active_mode_q <= active_mode_d;
        line_base_q   <= line_base_d;
        fb_addr_q     <= fb_addr_d;
        bar_px_q      <= bar_px_d;
        bar_k_q       <= bar_k_d;
        tag_q         <= tag_d;
        r_q           <= r_d;
        g_q           <= g_d;
        b_q           <= b_d;
        hs_q          <= hs_d;
        vs_q          <= vs_d;
        de_q          <= de_d;
        row_q         <= row_d;
        col_q         <= col_d;
      end
    end
  end

  assign fb_addr     = fb_addr_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign row_addr    = row_q;
  assign col_addr    = col_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - randomized bench for vga_scanout against a coordinate-level reference model
module tb_vga_scanout;

  localparam int HA = 8, HF = 2, HS = 2, HB = 2;
  localparam int VA = 4, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pix_ce = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [18:0] fb_addr;
  logic [11:0] fb_data;
  logic [3:0]  r, g, b;
  logic        hs, vs, de, frame_start;
  logic [9:0]  row_addr, col_addr;

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(0), .ADDR_W(19)
  ) dut (
    .clk(clk), .rst(rst), .pix_ce(pix_ce), .mode(mode),
    .fb_addr(fb_addr), .fb_data(fb_data),
    .r(r), .g(g), .b(b), .hs(hs), .vs(vs), .de(de),
    .row_addr(row_addr), .col_addr(col_addr), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  logic [11:0] mem [256];
  always @(posedge clk) fb_data <= mem[fb_addr[7:0]];

  int n_checks = 0;
  int n_err = 0;

  int          mh, mv;
  logic [1:0]  amode;
  logic [18:0] maddr;
  logic        p_hs, p_vs, p_de;
  int          p_h, p_v;
  logic [1:0]  p_mode;
  logic [18:0] p_addr;

  int   tickno = 0;
  int   last_fs = 0;
  bit   fs_seen = 0;
  bit   count_en = 0;
  int   hs_lo = 0, vs_lo = 0, de_hi = 0, fs_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", tag, got, exp, tickno);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mh = 0; mv = 0; amode = 2'd0; maddr = '0;
    p_hs = 0; p_vs = 0; p_de = 0; p_h = 0; p_v = 0; p_mode = 2'd0; p_addr = '0;
    fs_seen = 0;
  endtask

  task automatic do_reset(input bit ce);
    rst = 1'b1;
    pix_ce = ce;
    step();
    rst = 1'b0;
    pix_ce = 1'b0;
    model_reset();
    chk("rst_addr", 32'(fb_addr), 32'd0);
    chk("rst_rgb", 32'({r, g, b}), 32'd0);
    chk("rst_sync", 32'({hs, vs, de}), 32'b110);
    chk("rst_pos", 32'({row_addr, col_addr}), 32'd0);
    chk("rst_fstart", 32'(frame_start), 32'd0);
  endtask

  task automatic do_tick();
    logic [11:0] w, ergb;
    logic [2:0]  kk;
    logic        fs, hsr, vsr, der;
    fs = (mh == 0) && (mv == 0);
    if (fs) amode = mode;

    ergb = '0;
    if (p_de) begin
      if (p_mode == 2'd0 || p_mode == 2'd1) begin
        w = mem[p_addr[7:0]];
        ergb = {w[3:0], w[7:4], w[11:8]};
      end else if (p_mode == 2'd2) begin
        kk = 3'(p_h / (HA / 8));
        ergb = {{4{kk[2]}}, {4{kk[1]}}, {4{kk[0]}}};
      end
    end

    hsr = (mh >= HA + HF) && (mh < HA + HF + HS);
    vsr = (mv >= VA + VF) && (mv < VA + VF + VS);
    der = (mh < HA) && (mv < VA);
    if (amode >= 2'd2) maddr = '0;
    else if (der) maddr = (amode == 2'd0) ? 19'(mv * HA + mh) : 19'((mv / 2) * (HA / 2) + mh / 2);

    pix_ce = 1'b1;
    step();
    pix_ce = 1'b0;
    tickno++;

    chk("addr", 32'(fb_addr), 32'(maddr));
    chk("rgb", 32'({r, g, b}), 32'(ergb));
    chk("sync", 32'({hs, vs, de}), 32'({~p_hs, ~p_vs, p_de}));
    chk("pos", 32'({row_addr, col_addr}), 32'({10'(p_v), 10'(p_h)}));
    chk("fstart", 32'(frame_start), 32'(fs));

    if (frame_start) begin
      if (fs_seen) chk("fperiod", 32'(tickno - last_fs), 32'(HT * VT));
      last_fs = tickno;
      fs_seen = 1;
    end
    if (count_en) begin
      if (!hs) hs_lo++;
      if (!vs) vs_lo++;
      if (de) de_hi++;
      if (frame_start) fs_cnt++;
    end

    p_hs = hsr; p_vs = vsr; p_de = der; p_h = mh; p_v = mv; p_mode = amode; p_addr = maddr;
    mh++;
    if (mh == HT) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      int gap;
      gap = $urandom_range(1, 3);
      for (int j = 0; j < gap; j++) begin
        step();
        chk("fs_idle", 32'(frame_start), 32'd0);
      end
      do_tick();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
    model_reset();
    repeat (3) step();
    do_reset(1'b0);

    count_en = 1;
    run_ticks(HT * VT);
    count_en = 0;
    chk("hs_lo_frame", 32'(hs_lo), 32'(HS * VT));
    chk("vs_lo_frame", 32'(vs_lo), 32'(VS * HT));
    chk("de_frame", 32'(de_hi), 32'(HA * VA));
    chk("fs_frame", 32'(fs_cnt), 32'd1);

    mode = 2'd1;
    run_ticks(3 * HT * VT);

    mode = 2'd0;
    run_ticks(HT * VT + 40);
    mode = 2'd2;
    run_ticks(2 * HT * VT);

    mode = 2'd0;
    run_ticks(HT * VT);
    for (int i = 0; i < 2 * HT * VT && !(mh == 3 && mv == 2); i++) run_ticks(1);
    do_reset(1'b1);
    run_ticks(HT * VT);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 199) == 0) do_reset(1'($urandom_range(0, 1)));
      run_ticks(1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
